// File: rtl/mul_share_arbiter.sv
// Purpose : shares one pipelined 32x32 multiplier cell (low 32 product bits) between two
//           requesters with round-robin grant, routing each result back to its owner.
// Latency : accept in cycle T -> rsp_valid in cycle T+MUL_LATENCY+1; one accept per cycle aggregate.
// Backpr. : per-requester 2-credit limit; a stalled rsp port only blocks its own requester.
// Ports   : clk, reset (sync, active-high)
//           req0/req1 : *_valid in, *_ready out, *_src1/*_src2 in [31:0]
//           rsp0/rsp1 : *_valid out, *_ready in, *_result out [31:0]
//           mul_src1/mul_src2 out [31:0] to the cell, mul_result in [31:0] from the cell
module mul_share_arbiter #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_src1,
  input  logic [31:0] req0_src2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_src1,
  input  logic [31:0] req1_src2,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  input  logic [31:0] mul_result
);

  // Credits: operations accepted and not yet consumed (in flight + buffered).
  logic [1:0] cnt0_q, cnt0_d;
  logic [1:0] cnt1_q, cnt1_d;
  // 1 = requester 1 was granted last, so requester 0 wins the next contention.
  logic       last_grant_q, last_grant_d;

  // Owner tag pipeline, aligned with the multiplier cell's internal stages.
  logic [MUL_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [MUL_LATENCY-1:0] tag_id_q, tag_id_d;

  // Two-entry result FIFO per requester: [requester][entry].
  logic [1:0][1:0][31:0] fifo_mem_q, fifo_mem_d;
  logic [1:0]            fifo_wptr_q, fifo_wptr_d;
  logic [1:0]            fifo_rptr_q, fifo_rptr_d;
  logic [1:0][1:0]       fifo_occ_q, fifo_occ_d;

  logic       elig0, elig1;
  logic       grant0, grant1, accept;
  logic [1:0] wr_en, rd_en;
  logic [1:0] rsp_vld;

  // Grant looks only at request valids and pre-handshake credits, never at rsp_ready.
  always_comb begin
    elig0  = req0_valid & (cnt0_q < 2'd2);
    elig1  = req1_valid & (cnt1_q < 2'd2);
    grant0 = ~reset & elig0 & (~elig1 | last_grant_q);
    grant1 = ~reset & elig1 & (~elig0 | ~last_grant_q);
    accept = grant0 | grant1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign mul_src1   = grant0 ? req0_src1 : (grant1 ? req1_src1 : 32'd0);
  assign mul_src2   = grant0 ? req0_src2 : (grant1 ? req1_src2 : 32'd0);

  // Outputs are forced low during reset so nothing stale leaks in the first reset cycle.
  always_comb begin
    rsp_vld[0] = ~reset & (fifo_occ_q[0] != 2'd0);
    rsp_vld[1] = ~reset & (fifo_occ_q[1] != 2'd0);
    rd_en[0]   = rsp_vld[0] & rsp0_ready;
    rd_en[1]   = rsp_vld[1] & rsp1_ready;
    wr_en[0]   = tag_vld_q[MUL_LATENCY-1] & ~tag_id_q[MUL_LATENCY-1];
    wr_en[1]   = tag_vld_q[MUL_LATENCY-1] &  tag_id_q[MUL_LATENCY-1];
  end

  assign rsp0_valid  = rsp_vld[0];
  assign rsp1_valid  = rsp_vld[1];
  assign rsp0_result = reset ? 32'd0 : fifo_mem_q[0][fifo_rptr_q[0]];
  assign rsp1_result = reset ? 32'd0 : fifo_mem_q[1][fifo_rptr_q[1]];

  always_comb begin
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = accept;
    tag_id_d[0]  = grant1;
    for (int s = 1; s < MUL_LATENCY; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end
  end

  always_comb begin
    last_grant_d = accept ? grant1 : last_grant_q;
    // Accept and consume in the same cycle cancel out.
    cnt0_d = cnt0_q + {1'b0, grant0} - {1'b0, rd_en[0]};
    cnt1_d = cnt1_q + {1'b0, grant1} - {1'b0, rd_en[1]};
  end

  // Credits guarantee a free slot whenever a tag retires, so no full check is needed.
  always_comb begin
    fifo_mem_d  = fifo_mem_q;
    fifo_wptr_d = fifo_wptr_q;
    fifo_rptr_d = fifo_rptr_q;
    fifo_occ_d  = fifo_occ_q;
    for (int i = 0; i < 2; i++) begin
      if (wr_en[i]) begin
        fifo_mem_d[i][fifo_wptr_q[i]] = mul_result;
        fifo_wptr_d[i]                = ~fifo_wptr_q[i];
      end
      if (rd_en[i]) begin
        fifo_rptr_d[i] = ~fifo_rptr_q[i];
      end
      case ({wr_en[i], rd_en[i]})
        2'b10:   fifo_occ_d[i] = fifo_occ_q[i] + 2'd1;
        2'b01:   fifo_occ_d[i] = fifo_occ_q[i] - 2'd1;
        default: fifo_occ_d[i] = fifo_occ_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q       <= 2'd0;
      cnt1_q       <= 2'd0;
      last_grant_q <= 1'b1;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      fifo_mem_q   <= '0;
      fifo_wptr_q  <= '0;
      fifo_rptr_q  <= '0;
      fifo_occ_q   <= '0;
    end else begin
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
      last_grant_q <= last_grant_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      fifo_mem_q   <= fifo_mem_d;
      fifo_wptr_q  <= fifo_wptr_d;
      fifo_rptr_q  <= fifo_rptr_d;
      fifo_occ_q   <= fifo_occ_d;
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: two instances (MUL_LATENCY 1 and 3), each with a
// bench-side pipelined multiplier cell; index k selects the instance under test.
module tb_mul_share_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst;
  logic [1:0]       r0v, r0r, r1v, r1r;
  logic [1:0][31:0] r0a, r0b, r1a, r1b;
  logic [1:0]       s0v, s0r, s1v, s1r;
  logic [1:0][31:0] s0d, s1d, ma, mb, mres;
  logic [31:0]      p3a, p3b;

  int passed = 0;
  int total  = 0;

  mul_share_arbiter #(.MUL_LATENCY(1)) u_l1 (
    .clk(clk), .reset(rst[0]),
    .req0_valid(r0v[0]), .req0_ready(r0r[0]), .req0_src1(r0a[0]), .req0_src2(r0b[0]),
    .req1_valid(r1v[0]), .req1_ready(r1r[0]), .req1_src1(r1a[0]), .req1_src2(r1b[0]),
    .rsp0_valid(s0v[0]), .rsp0_ready(s0r[0]), .rsp0_result(s0d[0]),
    .rsp1_valid(s1v[0]), .rsp1_ready(s1r[0]), .rsp1_result(s1d[0]),
    .mul_src1(ma[0]), .mul_src2(mb[0]), .mul_result(mres[0])
  );

  mul_share_arbiter #(.MUL_LATENCY(3)) u_l3 (
    .clk(clk), .reset(rst[1]),
    .req0_valid(r0v[1]), .req0_ready(r0r[1]), .req0_src1(r0a[1]), .req0_src2(r0b[1]),
    .req1_valid(r1v[1]), .req1_ready(r1r[1]), .req1_src1(r1a[1]), .req1_src2(r1b[1]),
    .rsp0_valid(s0v[1]), .rsp0_ready(s0r[1]), .rsp0_result(s0d[1]),
    .rsp1_valid(s1v[1]), .rsp1_ready(s1r[1]), .rsp1_result(s1d[1]),
    .mul_src1(ma[1]), .mul_src2(mb[1]), .mul_result(mres[1])
  );

  // Multiplier cells: 1-stage for instance 0, 3-stage for instance 1.
  always_ff @(posedge clk) begin
    mres[0] <= ma[0] * mb[0];
    p3a     <= ma[1] * mb[1];
    p3b     <= p3a;
    mres[1] <= p3b;
  end

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    r0v[k] = 1'b0; r1v[k] = 1'b0;
    r0a[k] = 32'd0; r0b[k] = 32'd0; r1a[k] = 32'd0; r1b[k] = 32'd0;
    s0r[k] = 1'b1; s1r[k] = 1'b1;
  endtask

  task automatic test_reset(input int k);
    rst[k] = 1'b1;
    r0v[k] = 1'b1; r1v[k] = 1'b1;
    r0a[k] = 32'h5; r0b[k] = 32'h6; r1a[k] = 32'h7; r1b[k] = 32'h8;
    cyc; cyc; #1;
    total++;
    if ({r0r[k], r1r[k]} !== 2'b00) $display("FAIL reset_ready k=%0d got %b want 00", k, {r0r[k], r1r[k]});
    else passed++;
    total++;
    if ({s0v[k], s1v[k]} !== 2'b00) $display("FAIL reset_rsp_valid k=%0d got %b want 00", k, {s0v[k], s1v[k]});
    else passed++;
    total++;
    if (s0d[k] !== 32'd0 || s1d[k] !== 32'd0) $display("FAIL reset_result k=%0d got %h %h want 0 0", k, s0d[k], s1d[k]);
    else passed++;
    total++;
    if (ma[k] !== 32'd0 || mb[k] !== 32'd0) $display("FAIL reset_mul_src k=%0d got %h %h want 0 0", k, ma[k], mb[k]);
    else passed++;
    rst[k] = 1'b0;
    idle(k);
    cyc;
  endtask

  // Both valid: grants 0,1,0,1 starting from reset state; results routed per port in order.
  task automatic test_contention(input int k);
    logic [31:0] e0 [2];
    logic [31:0] e1 [2];
    int i0, i1;
    e0[0] = 32'd15;     e0[1] = 32'd77;
    e1[0] = 32'h10000;  e1[1] = 32'hFFFFFFFE;
    i0 = 0; i1 = 0;
    for (int c = 0; c < 16; c++) begin
      r0v[k] = (c < 3);
      r1v[k] = (c < 4);
      if ((c + 1) / 2 == 0) begin r0a[k] = 32'd3; r0b[k] = 32'd5; end
      else                  begin r0a[k] = 32'd7; r0b[k] = 32'd11; end
      if (c / 2 == 0) begin r1a[k] = 32'h100; r1b[k] = 32'h100; end
      else            begin r1a[k] = 32'hFFFFFFFF; r1b[k] = 32'd2; end
      #1;
      if (c < 4) begin
        total++;
        if (r0r[k] !== (c % 2 == 0) || r1r[k] !== (c % 2 == 1))
          $display("FAIL contention_grant k=%0d cycle=%0d got r0=%b r1=%b want r0=%b r1=%b",
                   k, c, r0r[k], r1r[k], (c % 2 == 0), (c % 2 == 1));
        else passed++;
      end
      if (s0v[k]) begin
        total++;
        if (i0 >= 2) $display("FAIL contention_rsp0_extra k=%0d got %h want none", k, s0d[k]);
        else if (s0d[k] !== e0[i0]) $display("FAIL contention_rsp0 k=%0d idx=%0d got %h want %h", k, i0, s0d[k], e0[i0]);
        else passed++;
        i0++;
      end
      if (s1v[k]) begin
        total++;
        if (i1 >= 2) $display("FAIL contention_rsp1_extra k=%0d got %h want none", k, s1d[k]);
        else if (s1d[k] !== e1[i1]) $display("FAIL contention_rsp1 k=%0d idx=%0d got %h want %h", k, i1, s1d[k], e1[i1]);
        else passed++;
        i1++;
      end
      cyc;
    end
    total++;
    if (i0 !== 2 || i1 !== 2) $display("FAIL contention_count k=%0d got %0d/%0d want 2/2", k, i0, i1);
    else passed++;
    idle(k);
  endtask

  task automatic test_basic(input int k);
    int L;
    L = lat(k);
    r0v[k] = 1'b1; r0a[k] = 32'h00010002; r0b[k] = 32'h00030004;
    #1;
    total++;
    if (r0r[k] !== 1'b1 || ma[k] !== 32'h00010002 || mb[k] !== 32'h00030004)
      $display("FAIL basic_accept k=%0d got ready=%b src=%h,%h want 1 00010002,00030004", k, r0r[k], ma[k], mb[k]);
    else passed++;
    cyc;
    r0v[k] = 1'b0;
    for (int c = 1; c <= L + 1; c++) begin
      #1;
      total++;
      if (s0v[k] !== (c == L + 1) || s1v[k] !== 1'b0)
        $display("FAIL basic_latency k=%0d cycle=%0d got rsp0=%b rsp1=%b want rsp0=%b rsp1=0", k, c, s0v[k], s1v[k], (c == L + 1));
      else passed++;
      if (c == L + 1) begin
        total++;
        if (s0d[k] !== 32'h000A0008) $display("FAIL basic_result k=%0d got %h want 000a0008", k, s0d[k]);
        else passed++;
      end
      cyc;
    end
    #1;
    total++;
    if (s0v[k] !== 1'b0) $display("FAIL basic_drained k=%0d got %b want 0", k, s0v[k]);
    else passed++;
    idle(k);
  endtask

  task automatic test_wrap(input int k);
    int L;
    L = lat(k);
    for (int c = 0; c <= L + 3; c++) begin
      r1v[k] = (c == 0); r1a[k] = 32'hFFFFFFFF; r1b[k] = 32'hFFFFFFFF;
      r0v[k] = (c == 1); r0a[k] = 32'h12345678; r0b[k] = 32'h00000010;
      #1;
      if (c == 0) begin
        total++;
        if (r1r[k] !== 1'b1) $display("FAIL wrap_accept1 k=%0d got %b want 1", k, r1r[k]);
        else passed++;
      end
      if (c == 1) begin
        total++;
        if (r0r[k] !== 1'b1) $display("FAIL wrap_accept0 k=%0d got %b want 1", k, r0r[k]);
        else passed++;
      end
      total++;
      if (s1v[k] !== (c == L + 1) || s0v[k] !== (c == L + 2))
        $display("FAIL wrap_valid k=%0d cycle=%0d got rsp0=%b rsp1=%b want rsp0=%b rsp1=%b",
                 k, c, s0v[k], s1v[k], (c == L + 2), (c == L + 1));
      else passed++;
      if (c == L + 1) begin
        total++;
        if (s1d[k] !== 32'h00000001) $display("FAIL wrap_rsp1 k=%0d got %h want 00000001", k, s1d[k]);
        else passed++;
      end
      if (c == L + 2) begin
        total++;
        if (s0d[k] !== 32'h23456780) $display("FAIL wrap_rsp0 k=%0d got %h want 23456780", k, s0d[k]);
        else passed++;
      end
      cyc;
    end
    idle(k);
  endtask

  task automatic test_backpressure(input int k);
    logic seen;
    s0r[k] = 1'b0; s1r[k] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      r0v[k] = 1'b1;
      if (c == 0)      begin r0a[k] = 32'd6;     r0b[k] = 32'd7; end
      else if (c == 1) begin r0a[k] = 32'h10000; r0b[k] = 32'h10000; end
      else             begin r0a[k] = 32'd9;     r0b[k] = 32'd9; end
      r1v[k] = (c == 2 || c == 3);
      r1a[k] = 32'(c); r1b[k] = 32'(c);
      #1;
      total++;
      if (r0r[k] !== (c < 2)) $display("FAIL bp_req0_ready k=%0d cycle=%0d got %b want %b", k, c, r0r[k], (c < 2));
      else passed++;
      if (c == 2 || c == 3) begin
        total++;
        if (r1r[k] !== 1'b1) $display("FAIL bp_req1_ready k=%0d cycle=%0d got %b want 1", k, c, r1r[k]);
        else passed++;
      end
      cyc;
    end
    r1v[k] = 1'b0; s0r[k] = 1'b1;
    #1;
    total++;
    if (s0v[k] !== 1'b1 || s0d[k] !== 32'd42) $display("FAIL bp_first k=%0d got v=%b %h want 1 0000002a", k, s0v[k], s0d[k]);
    else passed++;
    total++;
    if (r0r[k] !== 1'b0) $display("FAIL bp_still_blocked k=%0d got %b want 0", k, r0r[k]);
    else passed++;
    cyc;
    #1;
    total++;
    if (s0v[k] !== 1'b1 || s0d[k] !== 32'd0) $display("FAIL bp_second k=%0d got v=%b %h want 1 00000000", k, s0v[k], s0d[k]);
    else passed++;
    total++;
    if (r0r[k] !== 1'b1) $display("FAIL bp_reaccept k=%0d got %b want 1", k, r0r[k]);
    else passed++;
    cyc;
    r0v[k] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      #1;
      if (s0v[k] && !seen) begin
        seen = 1'b1;
        total++;
        if (s0d[k] !== 32'd81) $display("FAIL bp_third k=%0d got %h want 00000051", k, s0d[k]);
        else passed++;
      end
      cyc;
    end
    total++;
    if (!seen) $display("FAIL bp_third_timeout k=%0d got none want 00000051", k);
    else passed++;
    idle(k);
  endtask

  task automatic test_simul(input int k);
    int L;
    int idx;
    logic [31:0] e [2];
    L = lat(k);
    e[0] = 32'd20; e[1] = 32'd0;
    s0r[k] = 1'b0;
    r0v[k] = 1'b1; r0a[k] = 32'd2; r0b[k] = 32'd3;
    #1;
    total++;
    if (r0r[k] !== 1'b1) $display("FAIL simul_fill0 k=%0d got %b want 1", k, r0r[k]);
    else passed++;
    cyc;
    r0a[k] = 32'd4; r0b[k] = 32'd5;
    #1;
    total++;
    if (r0r[k] !== 1'b1) $display("FAIL simul_fill1 k=%0d got %b want 1", k, r0r[k]);
    else passed++;
    cyc;
    r0v[k] = 1'b0;
    repeat (L + 1) cyc;
    r0v[k] = 1'b1; r0a[k] = 32'h80000000; r0b[k] = 32'd2; s0r[k] = 1'b1;
    #1;
    total++;
    if (r0r[k] !== 1'b0) $display("FAIL simul_no_accept k=%0d got %b want 0", k, r0r[k]);
    else passed++;
    total++;
    if (s0v[k] !== 1'b1 || s0d[k] !== 32'd6) $display("FAIL simul_head k=%0d got v=%b %h want 1 00000006", k, s0v[k], s0d[k]);
    else passed++;
    cyc;
    s0r[k] = 1'b0;
    #1;
    total++;
    if (r0r[k] !== 1'b1) $display("FAIL simul_next_accept k=%0d got %b want 1", k, r0r[k]);
    else passed++;
    cyc;
    #1;
    total++;
    if (r0r[k] !== 1'b0) $display("FAIL simul_cnt_full k=%0d got ready=%b want 0", k, r0r[k]);
    else passed++;
    r0v[k] = 1'b0; s0r[k] = 1'b1;
    idx = 0;
    for (int n = 0; n < 12; n++) begin
      #1;
      if (s0v[k]) begin
        total++;
        if (idx >= 2) $display("FAIL simul_drain_extra k=%0d got %h want none", k, s0d[k]);
        else if (s0d[k] !== e[idx]) $display("FAIL simul_drain k=%0d idx=%0d got %h want %h", k, idx, s0d[k], e[idx]);
        else passed++;
        idx++;
      end
      cyc;
    end
    total++;
    if (idx !== 2) $display("FAIL simul_drain_count k=%0d got %0d want 2", k, idx);
    else passed++;
    idle(k);
  endtask

  task automatic test_reset_mid(input int k);
    int L;
    int n0, n1;
    L = lat(k);
    r0v[k] = 1'b1; r0a[k] = 32'd5; r0b[k] = 32'd5;
    #1;
    total++;
    if (r0r[k] !== 1'b1) $display("FAIL rmid_accept k=%0d got %b want 1", k, r0r[k]);
    else passed++;
    cyc;
    rst[k] = 1'b1;
    r0v[k] = 1'b1; r1v[k] = 1'b1;
    r0a[k] = 32'd7; r0b[k] = 32'd7; r1a[k] = 32'd8; r1b[k] = 32'd8;
    #1;
    total++;
    if ({r0r[k], r1r[k], s0v[k], s1v[k]} !== 4'b0000)
      $display("FAIL rmid_ctrl k=%0d got %b want 0000", k, {r0r[k], r1r[k], s0v[k], s1v[k]});
    else passed++;
    total++;
    if (s0d[k] !== 32'd0 || s1d[k] !== 32'd0 || ma[k] !== 32'd0 || mb[k] !== 32'd0)
      $display("FAIL rmid_data k=%0d got %h %h %h %h want all 0", k, s0d[k], s1d[k], ma[k], mb[k]);
    else passed++;
    cyc;
    rst[k] = 1'b0;
    r0v[k] = 1'b0; r1v[k] = 1'b0;
    for (int n = 0; n < L + 3; n++) begin
      #1;
      total++;
      if (s0v[k] !== 1'b0 || s1v[k] !== 1'b0)
        $display("FAIL rmid_discard k=%0d cycle=%0d got rsp0=%b rsp1=%b want 0 0", k, n, s0v[k], s1v[k]);
      else passed++;
      cyc;
    end
    r0v[k] = 1'b1; r0a[k] = 32'h11; r0b[k] = 32'h11;
    r1v[k] = 1'b1; r1a[k] = 32'h20; r1b[k] = 32'h30;
    #1;
    total++;
    if (r0r[k] !== 1'b1 || r1r[k] !== 1'b0)
      $display("FAIL rmid_first_contention k=%0d got r0=%b r1=%b want 1 0", k, r0r[k], r1r[k]);
    else passed++;
    cyc;
    r0v[k] = 1'b0;
    #1;
    total++;
    if (r1r[k] !== 1'b1) $display("FAIL rmid_second_grant k=%0d got %b want 1", k, r1r[k]);
    else passed++;
    cyc;
    r1v[k] = 1'b0;
    n0 = 0; n1 = 0;
    for (int n = 0; n < 10; n++) begin
      #1;
      if (s0v[k]) begin
        total++;
        if (s0d[k] !== 32'h121) $display("FAIL rmid_rsp0 k=%0d got %h want 00000121", k, s0d[k]);
        else passed++;
        n0++;
      end
      if (s1v[k]) begin
        total++;
        if (s1d[k] !== 32'h600) $display("FAIL rmid_rsp1 k=%0d got %h want 00000600", k, s1d[k]);
        else passed++;
        n1++;
      end
      cyc;
    end
    total++;
    if (n0 !== 1 || n1 !== 1) $display("FAIL rmid_count k=%0d got %0d/%0d want 1/1", k, n0, n1);
    else passed++;
    idle(k);
  endtask

  initial begin
    rst = 2'b11;
    idle(0);
    idle(1);
    for (int k = 0; k < 2; k++) begin
      test_reset(k);
      test_contention(k);
      test_basic(k);
      test_wrap(k);
      test_backpressure(k);
      test_simul(k);
      test_reset_mid(k);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
